mmcm_div_request: RTL and testbench
===================================

# mmcm_div_request

Request front-end for the `xilinx7_reconfig` DRP engine. It accepts a CLKOUT0 integer divide value over a valid/ready handshake and encodes it into the engine's HIGH_TIME / LOW_TIME / EDGE / NO_COUNT fields. It then pulses `start_reconfig`, waits for the engine to finish and for the MMCM to hold lock, and reports success or failure. It sits between user or test logic (sweep counters, UART commands) and the reconfig engine, in the `dclk` domain, and replaces ad-hoc counter logic that drives `half_period`/`start_reconfig` directly.

## Interface
Parameters:
- `DEFAULT_DIV`, 20: divide encoded on the field outputs out of reset; range 1..63.
- `LOCK_FILTER`, 16: consecutive `mmcm_locked` high cycles required to declare lock.
- `LOCK_TIMEOUT`, 1048576: cycles allowed from `start_reconfig` to a filtered lock. Used only with `MMCM_LOCK_TIMEOUT_EN`.
- `MAX_RETRY`, 3: re-issues allowed after a timeout. Used only with `MMCM_LOCK_TIMEOUT_EN`.

Ports:
- `dclk` in 1: DRP clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a divide request is present.
- `req_div` in 7: requested CLKOUT0 divide.
- `req_ready` out 1: the block can accept a request.
- `eng_ready` in 1: `ready` from the reconfig engine.
- `reconfig_done` in 1: `reconfig_done` from the reconfig engine (level or pulse).
- `mmcm_locked` in 1: MMCM LOCKED.
- `start_reconfig` out 1: single-cycle start strobe to the engine.
- `clkout0_high_time` out 6, `clkout0_low_time` out 6, `clkout0_edge` out 1, `clkout0_no_count` out 1: encoded counter fields.
- `busy` out 1: a reconfiguration is in flight.
- `cur_div` out 7: last divide confirmed locked.
- `err_range` out 1: one-cycle pulse when a request is rejected as out of range.
- `err_timeout` out 1: one-cycle pulse when retries are exhausted.

## Operation
States:
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: a request with 1≤`req_div`≤63 latches the new fields and goes to SETUP.
  - Any other value is consumed, pulses `err_range`, leaves the fields unchanged and stays in IDLE.
- **SETUP**: one cycle; the fields are stable before start is asserted. Go to ISSUE.
- **ISSUE**: wait for `eng_ready`=1, then assert `start_reconfig` for exactly one cycle and go to WAIT_DONE.
- **WAIT_DONE**: wait for `reconfig_done`=1. Clear the lock counter, then go to WAIT_LOCK.
- **WAIT_LOCK**
  - The counter increments while `mmcm_locked`=1 and clears to 0 whenever it is 0.
  - When the counter reaches `LOCK_FILTER`: `cur_div` ← the latched divide, then go to IDLE.

Divide encoding (D = divide value):
- D=1: `no_count`=1, high=1, low=1, `edge`=0.
- D≥2: `no_count`=0, high=D>>1, low=D−(D>>1), `edge`=D[0].
- Examples:
  - D=20 gives 10/10/0.
  - D=21 gives 10/11/1.
  - D=63 gives 31/32/1.

Outputs:
- `busy` = state≠IDLE.
- `req_ready` = (state==IDLE) & ~`rst`.
- The field outputs hold their value at all times except on acceptance of an in-range request.

## Timing
- Reset values:
  - State IDLE.
  - `start_reconfig`=0, `busy`=0, `err_range`=0, `err_timeout`=0.
  - `cur_div`=`DEFAULT_DIV`; fields = encode(`DEFAULT_DIV`).
  - `req_ready`=0 while `rst` is high and 1 on the first cycle after.
- Handshake:
  - Acceptance happens on the edge where `req_valid`&`req_ready`.
  - The fields update on that same edge.
  - `start_reconfig` goes high at the earliest 2 edges after acceptance (SETUP, then ISSUE with `eng_ready`=1).
- `req_valid` while busy is not consumed; the requester holds it.
- `reconfig_done` and `mmcm_locked` are sampled only in their respective states. A stale `reconfig_done` already high on entry to WAIT_DONE is accepted.
- Lock loss during WAIT_LOCK restarts the filter; it is not an error.
- Minimum accept-to-IDLE time with an immediate done and lock: 2 + 1 + 1 + `LOCK_FILTER` cycles.
- `rst` mid-operation:
  - Everything returns to its reset values on that edge, including the fields (back to `DEFAULT_DIV`).
  - `start_reconfig` is low on that edge.

## Configuration
`MMCM_LOCK_TIMEOUT_EN`:
- Defined:
  - A timeout counter is cleared on each `start_reconfig` and runs through WAIT_DONE and WAIT_LOCK.
  - If it reaches `LOCK_TIMEOUT` before lock, the retry count increments and the block returns to ISSUE.
  - After `MAX_RETRY` re-issues, it pulses `err_timeout` and goes to IDLE with `cur_div` unchanged. The fields keep the failed value.
- Undefined: no counter; the block waits indefinitely; `err_timeout` is tied to 0.

## Test plan
- Reset, then idle:
  - Fields 10/10/0/0, `cur_div`=20, `req_ready`=1 on the first post-reset cycle.
- `req_div`=21, `eng_ready`=1, done after 5 cycles, locked held high:
  - Fields 10/11/1/0 on the acceptance edge.
  - One `start_reconfig` pulse 2 cycles later.
  - `cur_div`=21 after `LOCK_FILTER` lock cycles; `busy` falls the same cycle.
- `req_div`=0 and then `req_div`=64:
  - Each gives one `err_range` pulse; fields and state unchanged; no start pulse.
- `req_div`=1 with `eng_ready` held low for 50 cycles:
  - `no_count`=1.
  - No start until `eng_ready` rises, then exactly one pulse.
  - `req_ready`=0 throughout.
- Lock glitch: locked high 10 cycles, low 1 cycle, high again:
  - Completion occurs `LOCK_FILTER` cycles after the glitch.
- With `MMCM_LOCK_TIMEOUT_EN`, `LOCK_TIMEOUT`=100, locked held low:
  - 4 start pulses spaced 100 cycles apart, then `err_timeout`, IDLE, `cur_div` unchanged.
- Also: `rst` asserted in WAIT_LOCK returns the block to the reset values in one cycle.

Source files
------------

// File: rtl/mmcm_div_request.sv
// Request front-end for the xilinx7_reconfig DRP engine: encodes a CLKOUT0 divide, starts the
// engine, waits for done plus a filtered lock. Optional lock timeout/retry via MMCM_LOCK_TIMEOUT_EN.
module mmcm_div_request #(
    parameter int DEFAULT_DIV  = 20,
    parameter int LOCK_FILTER  = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int MAX_RETRY    = 3
) (
    input  logic       dclk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [6:0] req_div,
    output logic       req_ready,
    input  logic       eng_ready,
    input  logic       reconfig_done,
    input  logic       mmcm_locked,
    output logic       start_reconfig,
    output logic [5:0] clkout0_high_time,
    output logic [5:0] clkout0_low_time,
    output logic       clkout0_edge,
    output logic       clkout0_no_count,
    output logic       busy,
    output logic [6:0] cur_div,
    output logic       err_range,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT_DONE,
        WAIT_LOCK
    } state_t;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_b;
        logic       no_count;
    } fields_t;

    localparam int              LC_W        = $clog2(LOCK_FILTER + 1);
    localparam logic [LC_W-1:0] LOCK_TARGET = LC_W'(LOCK_FILTER);

    // Divide 1 bypasses the counter; otherwise the odd half-cycle goes to the low time.
    function automatic fields_t encode_div(input logic [5:0] d);
        fields_t f;
        if (d == 6'd1) begin
            f.high     = 6'd1;
            f.low      = 6'd1;
            f.edge_b   = 1'b0;
            f.no_count = 1'b1;
        end else begin
            f.high     = {1'b0, d[5:1]};
            f.low      = d - {1'b0, d[5:1]};
            f.edge_b   = d[0];
            f.no_count = 1'b0;
        end
        return f;
    endfunction

    localparam fields_t    RESET_FIELDS = encode_div(6'(DEFAULT_DIV));
    localparam logic [6:0] RESET_DIV    = 7'(DEFAULT_DIV);

    state_t          state_q, state_d;
    fields_t         fields_q, fields_d;
    logic [6:0]      div_q, div_d;
    logic [6:0]      cur_div_q, cur_div_d;
    logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
    logic            start_q, start_d;
    logic            err_range_q, err_range_d;
    logic            div_in_range;

`ifdef MMCM_LOCK_TIMEOUT_EN
    localparam int              TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam int              RT_W    = $clog2(MAX_RETRY + 2);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY);

    logic [TO_W-1:0] to_q, to_d;
    logic [RT_W-1:0] retry_q, retry_d;
    logic            err_to_q, err_to_d;
`endif

    assign div_in_range = (req_div != 7'd0) && !req_div[6];

    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        div_d       = div_q;
        cur_div_d   = cur_div_q;
        lock_cnt_d  = lock_cnt_q;
        start_d     = 1'b0;
        err_range_d = 1'b0;
`ifdef MMCM_LOCK_TIMEOUT_EN
        to_d        = to_q;
        retry_d     = retry_q;
        err_to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (div_in_range) begin
                        fields_d = encode_div(req_div[5:0]);
                        div_d    = req_div;
                        state_d  = SETUP;
`ifdef MMCM_LOCK_TIMEOUT_EN
                        retry_d  = '0;
`endif
                    end else begin
                        err_range_d = 1'b1;
                    end
                end
            end
            SETUP: state_d = ISSUE;
            ISSUE: begin
                if (eng_ready) begin
                    start_d = 1'b1;
                    state_d = WAIT_DONE;
`ifdef MMCM_LOCK_TIMEOUT_EN
                    // Counter equals edges elapsed since the start edge.
                    to_d    = TO_W'(1);
`endif
                end
            end
            WAIT_DONE: begin
                if (reconfig_done) begin
                    lock_cnt_d = '0;
                    state_d    = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_cnt_q == LOCK_TARGET) begin
                    cur_div_d = div_q;
                    state_d   = IDLE;
                end else if (mmcm_locked) begin
                    lock_cnt_d = lock_cnt_q + LC_W'(1);
                end else begin
                    lock_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MMCM_LOCK_TIMEOUT_EN
        // Progress (done seen, lock filtered) wins over a timeout landing on the same edge.
        if (state_q inside {WAIT_DONE, WAIT_LOCK}) begin
            to_d = to_q + TO_W'(1);
            if (state_d == state_q && to_q >= TO_LAST) begin
                if (retry_q == RT_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    retry_d = retry_q + RT_W'(1);
                    state_d = ISSUE;
                end
            end
        end
`endif
    end

    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q     <= IDLE;
            fields_q    <= RESET_FIELDS;
            div_q       <= RESET_DIV;
            cur_div_q   <= RESET_DIV;
            lock_cnt_q  <= '0;
            start_q     <= 1'b0;
            err_range_q <= 1'b0;
`ifdef MMCM_LOCK_TIMEOUT_EN
            to_q        <= '0;
            retry_q     <= '0;
            err_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            div_q       <= div_d;
            cur_div_q   <= cur_div_d;
            lock_cnt_q  <= lock_cnt_d;
            start_q     <= start_d;
            err_range_q <= err_range_d;
`ifdef MMCM_LOCK_TIMEOUT_EN
            to_q        <= to_d;
            retry_q     <= retry_d;
            err_to_q    <= err_to_d;
`endif
        end
    end

    assign req_ready         = (state_q == IDLE) & ~rst;
    assign busy              = (state_q != IDLE);
    assign start_reconfig    = start_q;
    assign clkout0_high_time = fields_q.high;
    assign clkout0_low_time  = fields_q.low;
    assign clkout0_edge      = fields_q.edge_b;
    assign clkout0_no_count  = fields_q.no_count;
    assign cur_div           = cur_div_q;
    assign err_range         = err_range_q;

`ifdef MMCM_LOCK_TIMEOUT_EN
    assign err_timeout = err_to_q;
`else
    // Timeout parameters are inert here but stay referenced so both builds share one parameter list.
    localparam logic TIMEOUT_PARAMS_OK = (LOCK_TIMEOUT >= 2) && (MAX_RETRY >= 0);
    assign err_timeout = 1'b0 & TIMEOUT_PARAMS_OK;
`endif

endmodule

// File: tb/tb_mmcm_div_request.sv
// Self-checking bench for mmcm_div_request: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the request/lock protocol.
module tb_mmcm_div_request;

    localparam int DEF_DIV = 20;
    localparam int LF      = 16;
    localparam int LT      = 100;
    localparam int MR      = 3;

    logic       dclk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [6:0] req_div;
    logic       req_ready;
    logic       eng_ready;
    logic       reconfig_done;
    logic       mmcm_locked;
    logic       start_reconfig;
    logic [5:0] clkout0_high_time;
    logic [5:0] clkout0_low_time;
    logic       clkout0_edge;
    logic       clkout0_no_count;
    logic       busy;
    logic [6:0] cur_div;
    logic       err_range;
    logic       err_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    mmcm_div_request #(
        .DEFAULT_DIV (DEF_DIV),
        .LOCK_FILTER (LF),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRY   (MR)
    ) dut (
        .dclk             (dclk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_div          (req_div),
        .req_ready        (req_ready),
        .eng_ready        (eng_ready),
        .reconfig_done    (reconfig_done),
        .mmcm_locked      (mmcm_locked),
        .start_reconfig   (start_reconfig),
        .clkout0_high_time(clkout0_high_time),
        .clkout0_low_time (clkout0_low_time),
        .clkout0_edge     (clkout0_edge),
        .clkout0_no_count (clkout0_no_count),
        .busy             (busy),
        .cur_div          (cur_div),
        .err_range        (err_range),
        .err_timeout      (err_timeout)
    );

    always #5 dclk = ~dclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_SETUP = 1, P_ISSUE = 2, P_WD = 3, P_WL = 4;

    int     m_ph, m_pend, m_cur, m_run, m_retry, ph0;
    int     m_high, m_low, m_edge, m_nc;
    longint cyc_n = 0;
    longint m_deadline;
    bit     m_start, m_erange, m_eto;
    bit     m_init = 0;

    task automatic m_encode(input int d);
        if (d == 1) begin
            m_high = 1; m_low = 1; m_edge = 0; m_nc = 1;
        end else begin
            m_high = d / 2; m_low = d - d / 2; m_edge = d % 2; m_nc = 0;
        end
    endtask

    always @(posedge dclk) begin
        cyc_n++;
        if (rst) begin
            m_init = 1; m_ph = P_IDLE; m_cur = DEF_DIV; m_pend = DEF_DIV;
            m_run = 0; m_retry = 0; m_start = 0; m_erange = 0; m_eto = 0;
            m_encode(DEF_DIV);
        end else if (m_init) begin
            m_start = 0; m_erange = 0; m_eto = 0;
            ph0 = m_ph;
            case (m_ph)
                P_IDLE: if (req_valid) begin
                    if (req_div >= 1 && req_div <= 63) begin
                        m_encode(int'(req_div)); m_pend = req_div; m_retry = 0; m_ph = P_SETUP;
                    end else m_erange = 1;
                end
                P_SETUP: m_ph = P_ISSUE;
                P_ISSUE: if (eng_ready) begin
                    m_start = 1; m_deadline = cyc_n + LT - 1; m_ph = P_WD;
                end
                P_WD: if (reconfig_done) begin m_run = 0; m_ph = P_WL; end
                P_WL: begin
                    if (m_run == LF) begin m_cur = m_pend; m_ph = P_IDLE; end
                    else m_run = mmcm_locked ? m_run + 1 : 0;
                end
                default: m_ph = P_IDLE;
            endcase
`ifdef MMCM_LOCK_TIMEOUT_EN
            if ((ph0 == P_WD || ph0 == P_WL) && m_ph == ph0 && cyc_n >= m_deadline) begin
                if (m_retry == MR) begin m_eto = 1; m_ph = P_IDLE; end
                else begin m_retry++; m_ph = P_ISSUE; end
            end
`endif
        end
    end

    always @(negedge dclk) begin
        if (m_init) begin
            chk("req_ready", req_ready, (m_ph == P_IDLE && !rst) ? 1 : 0);
            chk("busy", busy, (m_ph != P_IDLE) ? 1 : 0);
            chk("start", start_reconfig, m_start);
            chk("high", clkout0_high_time, m_high);
            chk("low", clkout0_low_time, m_low);
            chk("edge", clkout0_edge, m_edge);
            chk("no_count", clkout0_no_count, m_nc);
            chk("cur_div", cur_div, m_cur);
            chk("err_range", err_range, m_erange);
            chk("err_timeout", err_timeout, m_eto);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge dclk);
        #2;
    endtask

    task automatic chk_fields(input string name, input int h, input int l, input int e, input int nc);
        chk({name, "_high"}, clkout0_high_time, h);
        chk({name, "_low"}, clkout0_low_time, l);
        chk({name, "_edge"}, clkout0_edge, e);
        chk({name, "_nc"}, clkout0_no_count, nc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_k, start_k, nst, nrdy;
        rst = 1; req_valid = 0; req_div = 0; eng_ready = 1; reconfig_done = 0; mmcm_locked = 0;
        repeat (3) tick();
        chk("ready_in_reset", req_ready, 0);
        chk_fields("reset", 10, 10, 0, 0);
        chk("reset_cur_div", cur_div, 20);
        rst = 0;
        tick();
        chk("ready_after_reset", req_ready, 1);

        // Divide 21, done five edges after start, lock held.
        req_valid = 1; req_div = 21; mmcm_locked = 1;
        tick();
        req_valid = 0;
        chk_fields("d21", 10, 11, 1, 0);
        idle_k = 0; start_k = 0; nst = 0;
        for (int k = 1; k <= 40 && idle_k == 0; k++) begin
            reconfig_done = (k >= 7);
            tick();
            if (start_reconfig) begin nst++; start_k = k; end
            if (!busy) idle_k = k;
        end
        chk("d21_start_count", nst, 1);
        chk("d21_start_edge", start_k, 2);
        chk("d21_idle_edge", idle_k, 24);
        chk("d21_cur_div", cur_div, 21);

        // Out-of-range requests.
        reconfig_done = 0;
        req_valid = 1; req_div = 0;
        tick();
        chk("div0_err", err_range, 1);
        chk("div0_busy", busy, 0);
        chk_fields("div0", 10, 11, 1, 0);
        req_div = 64;
        tick();
        chk("div64_err", err_range, 1);
        chk("div64_start", start_reconfig, 0);
        req_valid = 0;
        tick();
        chk("err_cleared", err_range, 0);

        // Divide 1 with engine busy for 50 cycles.
        req_valid = 1; req_div = 1; eng_ready = 0;
        tick();
        req_valid = 0;
        chk_fields("d1", 1, 1, 0, 1);
        nst = 0; nrdy = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (start_reconfig) nst++;
            if (req_ready) nrdy++;
        end
        chk("d1_no_early_start", nst, 0);
        chk("d1_ready_low", nrdy, 0);
        eng_ready = 1;
        tick();
        chk("d1_start", start_reconfig, 1);
        tick();
        chk("d1_start_single", start_reconfig, 0);
        reconfig_done = 1;
        idle_k = 0;
        for (int k = 1; k <= 40 && idle_k == 0; k++) begin
            tick();
            if (!busy) idle_k = k;
        end
        chk("d1_completed", idle_k != 0, 1);
        chk("d1_cur_div", cur_div, 1);

        // Lock glitch: high, one low sample at edge 14, high again.
        req_valid = 1; req_div = 33;
        tick();
        req_valid = 0;
        chk_fields("d33", 16, 17, 1, 0);
        idle_k = 0;
        for (int k = 1; k <= 60 && idle_k == 0; k++) begin
            mmcm_locked = (k != 14);
            tick();
            if (!busy) idle_k = k;
        end
        chk("glitch_idle_edge", idle_k, 31);
        chk("glitch_cur_div", cur_div, 33);

        // Reset while waiting for lock.
        req_valid = 1; req_div = 40;
        tick();
        req_valid = 0;
        repeat (10) tick();
        chk("midrst_busy_before", busy, 1);
        rst = 1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_start", start_reconfig, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_cur_div", cur_div, 20);
        chk_fields("midrst", 10, 10, 0, 0);
        rst = 0;
        tick();
        chk("midrst_ready_after", req_ready, 1);

`ifdef MMCM_LOCK_TIMEOUT_EN
        begin
            int sk[$];
            int eto_k;
            req_valid = 1; req_div = 50; mmcm_locked = 0; reconfig_done = 1; eng_ready = 1;
            tick();
            req_valid = 0;
            idle_k = 0; eto_k = 0;
            for (int k = 1; k <= 450 && idle_k == 0; k++) begin
                tick();
                if (start_reconfig) sk.push_back(k);
                if (err_timeout) eto_k = k;
                if (!busy) idle_k = k;
            end
            chk("to_start_count", sk.size(), 4);
            foreach (sk[i]) chk("to_start_edge", sk[i], 2 + 100 * i);
            chk("to_err_edge", eto_k, 401);
            chk("to_idle_edge", idle_k, 401);
            chk("to_cur_div", cur_div, 20);
            chk_fields("to", 25, 25, 0, 0);
        end
`endif

        // Random traffic against the model.
        for (int k = 0; k < 15000; k++) begin
            rst           = ($urandom_range(0, 999) == 0);
            req_valid     = ($urandom_range(0, 3) == 0);
            req_div       = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                        : 7'($urandom_range(1, 63));
            eng_ready     = ($urandom_range(0, 3) != 0);
            reconfig_done = ($urandom_range(0, 2) == 0);
            mmcm_locked   = ($urandom_range(0, 15) != 0);
            tick();
        end
        rst = 0; req_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
